// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester and its wait timer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package apb_pkg;

    localparam int APB_ADDR_W    = 32;
    localparam int APB_DATA_W    = 32;
    localparam int APB_TIMEOUT   = 16;
    // Response data is carried at this width internally; DATA_W must not exceed it.
    localparam int APB_RSP_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [APB_RSP_MAX_W-1:0] rdata;
        logic                     err;
        logic                     timeout;
    } apb_rsp_t;

    // Wait counter width: enough to hold TIMEOUT itself, never narrower than 1 bit.
    function automatic int apb_cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting for pready; flags when the abort point is reached.
// Latency: expire is decoded from the count register, valid the cycle the count gets there.
// Backpressure: none; count saturates at TIMEOUT, and TIMEOUT = 0 ties expire low.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic pclk,
    input  logic preset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_timer_inputs;
            assign unused_timer_inputs = ^{pclk, preset, clr, en};
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = apb_cnt_w(TIMEOUT);

            logic [CW-1:0] cnt;

            // Saturating wait counter: cleared per command, advanced on each unready ACCESS cycle.
            always_ff @(posedge pclk or posedge preset) begin
                if (preset) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en && (cnt != CW'(TIMEOUT))) begin
                    cnt <= cnt + CW'(1);
                end
            end

            // The count equals the number of unready cycles already spent in ACCESS,
            // so TIMEOUT-1 means this is the TIMEOUT-th ACCESS cycle.
            assign expire = (cnt == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB3 requester: cmd valid/ready in, SETUP/ACCESS on the bus, buffered response out.
// Latency: handshake at edge 0 -> rsp_valid in cycle 3, plus one cycle per pready-low ACCESS cycle.
// Backpressure: response held until rsp_ready; cmd_ready is low from acceptance until the response is taken.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic              pclk,
    input  logic              preset,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB requester side
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_e state;
    apb_rsp_t   rsp_q;
    logic       cmd_hs;
    logic       timer_en;
    logic       timer_expire;

    // cmd_ready is a pure state decode so no input reaches it combinationally.
    assign cmd_ready = (state == IDLE);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign timer_en  = (state == ACCESS) && !pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk   (pclk),
        .preset (preset),
        .clr    (cmd_hs),
        .en     (timer_en),
        .expire (timer_expire)
    );

    assign rsp_rdata   = DATA_W'(rsp_q.rdata);
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

    // Transfer FSM with registered APB strobes, address/data latch and response buffer.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state     <= IDLE;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr   <= cmd_addr;
                        pwdata  <= cmd_wdata;
                        pwrite  <= cmd_write;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // pready is checked first so a completion on the last allowed cycle is not aborted.
                    if (pready) begin
                        rsp_q.rdata   <= pwrite ? '0 : APB_RSP_MAX_W'(prdata);
                        rsp_q.err     <= pslverr;
                        rsp_q.timeout <= 1'b0;
                        psel          <= 1'b0;
                        penable       <= 1'b0;
                        rsp_valid     <= 1'b1;
                        state         <= RESP;
                    end else if (timer_expire) begin
                        rsp_q.rdata   <= '0;
                        rsp_q.err     <= 1'b1;
                        rsp_q.timeout <= 1'b1;
                        psel          <= 1'b0;
                        penable       <= 1'b0;
                        rsp_valid     <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // SETUP always leads into ACCESS with the transfer attributes unchanged.
    a_setup_to_access: assert property (@(posedge pclk) disable iff (preset)
        (psel && !penable) |=> (psel && penable && $stable(paddr) && $stable(pwdata) && $stable(pwrite)));

    // A wait state without abort keeps the transfer on the bus unchanged.
    a_wait_stable: assert property (@(posedge pclk) disable iff (preset)
        (psel && penable && !pready && !timer_expire)
            |=> (psel && penable && $stable(paddr) && $stable(pwdata) && $stable(pwrite)));

    // A pending response is held stable until it is taken.
    a_rsp_hold: assert property (@(posedge pclk) disable iff (preset)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_q)));

    // No new command while a response is outstanding.
    a_no_cmd_in_resp: assert property (@(posedge pclk) disable iff (preset)
        rsp_valid |-> !cmd_ready);

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench: register-slave completer model plus a transaction-level reference model.
// Latency: expected latency per transfer derived from wait count and timeout.
// Backpressure: exercises held responses, queued commands and reset mid-transfer.
module tb_apb_master;

    localparam int TO = 4;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready, pslverr;

    always #5 pclk = ~pclk;

    apb_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pwrite      (pwrite),
        .psel        (psel),
        .penable     (penable),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- completer (register slave) model ----------------
    logic [31:0] smem [8] = '{32'h0, 32'h0, 32'h1234_9876, 32'hA5A5_0000,
                             32'h0, 32'h0, 32'h0, 32'h0};
    int          cfg_wait = 0;
    logic        cfg_err  = 1'b0;
    int          acc_cnt  = 0;

    assign pready  = psel && penable && (acc_cnt >= cfg_wait);
    assign pslverr = cfg_err;
    assign prdata  = smem[paddr[4:2]];

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready && pwrite && !pslverr)
            smem[paddr[4:2]] <= pwdata;
    end

    // ---------------- reference model: register contents as seen by requester ----------------
    logic [31:0] mmem [8] = '{32'h0, 32'h0, 32'h1234_9876, 32'hA5A5_0000,
                             32'h0, 32'h0, 32'h0, 32'h0};

    // One complete transfer; called and returning at a falling edge.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic serr, input int hold,
                          input logic q_next, input logic [31:0] q_addr,
                          output longint hs_time);
        logic        timed;
        int          acc, lat, pen, cyc, n;
        logic [31:0] exp_rd;
        logic        exp_err, addr_ok;

        timed   = (waits >= TO);
        acc     = timed ? TO : waits + 1;
        lat     = 2 + acc;
        exp_rd  = (wr || timed) ? 32'h0 : mmem[addr[4:2]];
        exp_err = timed || serr;
        if (wr && !exp_err) mmem[addr[4:2]] = wdata;

        cfg_wait  = waits;
        cfg_err   = serr;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge pclk);
            n++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge pclk);
        hs_time = $time;
        @(negedge pclk);
        cmd_valid = 1'b0;
        cyc = 1;
        pen = 0;
        addr_ok = 1'b1;
        while (!rsp_valid && cyc < 40) begin
            if (psel && penable) pen++;
            if (psel && !(paddr === addr && pwrite === wr && pwdata === wdata)) addr_ok = 1'b0;
            @(negedge pclk);
            cyc++;
        end
        chk("rsp_latency", cyc, lat);
        chk("penable_cycles", pen, acc);
        chk("bus_stable", addr_ok, 1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_timeout", rsp_timeout, timed);
        chk("psel_in_resp", psel, 0);

        if (q_next) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = q_addr;
            cmd_wdata = 32'h0;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge pclk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", {rsp_err, rsp_timeout}, {exp_err, timed});
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_psel", psel, 0);
        end
        rsp_ready = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk("rsp_consumed", rsp_valid, 0);
        chk("cmd_ready_after", cmd_ready, 1);
        if (q_next) chk("paddr_held", paddr, addr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
        $fatal(1);
    end

    initial begin
        longint t0, t1, t2;
        logic   seen;
        int     n;

        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;

        // reset values
        repeat (2) @(negedge pclk);
        chk("rst_psel_penable", {psel, penable}, 2'b00);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
        chk("rst_rdata", rsp_rdata, 0);
        preset = 1'b0;
        @(negedge pclk);
        chk("rst_cmd_ready", cmd_ready, 1);

        // directed: zero-wait write then read, reset default, wait states, slave error
        do_txn(1'b1, 32'h4, 32'hDEAD_BEEF, 0, 1'b0, 0, 1'b0, 32'h0, t0);
        do_txn(1'b0, 32'h4, 32'h0,         0, 1'b0, 0, 1'b0, 32'h0, t0);
        do_txn(1'b0, 32'h8, 32'h0,         0, 1'b0, 0, 1'b0, 32'h0, t0);
        do_txn(1'b0, 32'hC, 32'h0,         3, 1'b0, 0, 1'b0, 32'h0, t0);
        do_txn(1'b1, 32'h10, 32'h5555_AAAA, 0, 1'b1, 0, 1'b0, 32'h0, t0);
        do_txn(1'b0, 32'h10, 32'h0,        0, 1'b0, 0, 1'b0, 32'h0, t0);

        // timeout, then completion on the last allowed ACCESS cycle
        do_txn(1'b0, 32'h14, 32'h0, 100, 1'b0, 0, 1'b0, 32'h0, t0);
        do_txn(1'b0, 32'h8,  32'h0, TO - 1, 1'b0, 0, 1'b0, 32'h0, t0);

        // response backpressure with a queued command
        do_txn(1'b1, 32'h18, 32'h0BAD_F00D, 0, 1'b0, 5, 1'b1, 32'h18, t0);
        do_txn(1'b0, 32'h18, 32'h0, 0, 1'b0, 0, 1'b0, 32'h0, t0);

        // throughput with immediate response consumption
        do_txn(1'b1, 32'h0, 32'h1111_0001, 0, 1'b0, 0, 1'b0, 32'h0, t0);
        do_txn(1'b1, 32'h4, 32'h2222_0002, 0, 1'b0, 0, 1'b0, 32'h0, t1);
        do_txn(1'b0, 32'h0, 32'h0,         0, 1'b0, 0, 1'b0, 32'h0, t2);
        chk("throughput_1", t1 - t0, 40);
        chk("throughput_2", t2 - t1, 40);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic        wr, serr;
            logic [31:0] addr;
            int          waits, hold;
            wr    = 1'($urandom_range(0, 1));
            serr  = ($urandom_range(0, 7) == 0);
            waits = $urandom_range(0, 5);
            hold  = $urandom_range(0, 2);
            addr  = ($urandom & 32'hFFFF_FFE0) | (32'($urandom_range(0, 7)) << 2);
            do_txn(wr, addr, $urandom, waits, serr, hold, 1'b0, 32'h0, t0);
        end

        // reset during ACCESS
        cfg_wait  = 100;
        cfg_err   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h1C;
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        n = 0;
        while (!penable && n < 10) begin
            @(negedge pclk);
            n++;
        end
        chk("rst_reach_access", penable, 1);
        @(posedge pclk);
        #2;
        preset = 1'b1;
        #1;
        chk("rst_mid_psel", psel, 0);
        chk("rst_mid_penable", penable, 0);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge pclk);
        preset   = 1'b0;
        cfg_wait = 0;
        rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge pclk);
            if (rsp_valid || psel) seen = 1'b1;
        end
        chk("no_rsp_after_rst", seen, 0);
        chk("cmd_ready_after_rst", cmd_ready, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
